// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl
//   Streams a program into the instruction memory and then releases the core.
//   The loader offers one 64-bit word per beat. Each accepted word is written
//   to the next memory slot in the cycle after it is accepted. The last word
//   moves the controller through a one-cycle DRAIN state into RUN. In RUN the
//   fetch stage owns the memory address. A beat that would overflow the
//   memory sends the controller to a sticky ERROR state.
//
// Ports
//   clk, rstn        clock and synchronous active-low reset
//   ld_valid/ready   loader handshake; ld_ready is a decode of the state only
//   ld_data, ld_last word offered by the loader, plus end-of-program marker
//   fetch_addr       word index from the fetch stage (used only in RUN)
//   mem_addr/din/we  instruction memory port (byte address, write data, write enable)
//   core_hold        holds the fetch stage until RUN is reached
//   run_start        one-cycle pulse in the first RUN cycle
//   load_err         sticky overflow flag
//   word_count       number of words accepted since reset
module imem_load_ctrl #(
  parameter int DEPTH_LOG2 = 14
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ld_valid,
  input  logic [63:0]           ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  input  logic [31:0]           fetch_addr,
  output logic [31:0]           mem_addr,
  output logic [63:0]           mem_din,
  output logic                  mem_we,
  output logic                  core_hold,
  output logic                  run_start,
  output logic                  load_err,
  output logic [DEPTH_LOG2:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_RUN,
    S_ERROR
  } state_t;

  // The write pointer equals this value once every memory slot is filled.
  localparam logic [DEPTH_LOG2:0] WPTR_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  state_t                state_reg;
  logic [DEPTH_LOG2:0]   wptr_reg;
  logic [31:0]           mem_addr_reg;
  logic [63:0]           mem_din_reg;
  logic                  mem_we_reg;
  logic                  run_start_reg;
  logic                  load_err_reg;
  logic                  accept;

  assign ld_ready = (state_reg == S_IDLE) || (state_reg == S_LOAD);
  assign accept   = ld_valid && ld_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= S_IDLE;
      wptr_reg      <= '0;
      mem_addr_reg  <= '0;
      mem_din_reg   <= '0;
      mem_we_reg    <= 1'b0;
      run_start_reg <= 1'b0;
      load_err_reg  <= 1'b0;
    end else begin
      // Write strobe and start pulse last exactly one cycle.
      mem_we_reg    <= 1'b0;
      run_start_reg <= 1'b0;
      case (state_reg)
        S_IDLE, S_LOAD: begin
          if (accept) begin
            if (wptr_reg == WPTR_FULL) begin
              // The memory has no free slot. The word is dropped and the
              // pointer is frozen. A final word that arrives here cannot be
              // stored either, so it is also treated as an overflow.
              state_reg    <= S_ERROR;
              load_err_reg <= 1'b1;
            end else begin
              mem_we_reg   <= 1'b1;
              // Shifting the word index left by 3 gives the byte address
              // {wptr[28:0], 3'b000}.
              mem_addr_reg <= 32'(wptr_reg) << 3;
              mem_din_reg  <= ld_data;
              wptr_reg     <= wptr_reg + 1'b1;
              state_reg    <= ld_last ? S_DRAIN : S_LOAD;
            end
          end
        end
        S_DRAIN: begin
          // The final write is issued during this cycle. RUN starts next.
          state_reg     <= S_RUN;
          run_start_reg <= 1'b1;
        end
        default: begin
          // RUN and ERROR are left only through reset.
          state_reg <= state_reg;
        end
      endcase
    end
  end

  // In RUN the fetch stage drives the address directly, unless a write is
  // still in flight. Otherwise the last registered address is held.
  assign mem_addr   = ((state_reg == S_RUN) && !mem_we_reg) ? (fetch_addr << 3)
                                                             : mem_addr_reg;
  assign mem_din    = mem_din_reg;
  assign mem_we     = mem_we_reg;
  assign core_hold  = (state_reg != S_RUN);
  assign run_start  = run_start_reg;
  assign load_err   = load_err_reg;
  assign word_count = wptr_reg;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl. It uses two instances: index 0 has the default
// depth and index 1 has DEPTH_LOG2=2 for the overflow cases. Expected memory
// writes are pushed to a per-instance queue when a beat is driven. They are
// popped and compared when the instance raises mem_we.
module tb_imem_load_ctrl;

  logic        clk;
  logic        rstn       [2];
  logic        ld_valid   [2];
  logic [63:0] ld_data    [2];
  logic        ld_last    [2];
  logic        ld_ready   [2];
  logic [31:0] fetch_addr [2];
  logic [31:0] mem_addr   [2];
  logic [63:0] mem_din    [2];
  logic        mem_we     [2];
  logic        core_hold  [2];
  logic        run_start  [2];
  logic        load_err   [2];
  logic [14:0] wc0;
  logic [2:0]  wc1;

  int tests = 0;
  int fails = 0;

  logic [95:0] sb0[$];
  logic [95:0] sb1[$];

  // Small reference model: next expected word index, capacity, and whether
  // the instance still accepts beats.
  int m_wptr [2];
  int m_full [2];
  bit m_acc  [2];

  imem_load_ctrl dut (
    .clk(clk), .rstn(rstn[0]),
    .ld_valid(ld_valid[0]), .ld_data(ld_data[0]), .ld_last(ld_last[0]),
    .ld_ready(ld_ready[0]), .fetch_addr(fetch_addr[0]),
    .mem_addr(mem_addr[0]), .mem_din(mem_din[0]), .mem_we(mem_we[0]),
    .core_hold(core_hold[0]), .run_start(run_start[0]), .load_err(load_err[0]),
    .word_count(wc0)
  );

  imem_load_ctrl #(.DEPTH_LOG2(2)) dut_s (
    .clk(clk), .rstn(rstn[1]),
    .ld_valid(ld_valid[1]), .ld_data(ld_data[1]), .ld_last(ld_last[1]),
    .ld_ready(ld_ready[1]), .fetch_addr(fetch_addr[1]),
    .mem_addr(mem_addr[1]), .mem_din(mem_din[1]), .mem_we(mem_we[1]),
    .core_hold(core_hold[1]), .run_start(run_start[1]), .load_err(load_err[1]),
    .word_count(wc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [95:0] got, logic [95:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wc(int k);
    return (k == 0) ? 32'(wc0) : 32'(wc1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int k, logic [95:0] v);
    if (k == 0) sb0.push_back(v);
    else        sb1.push_back(v);
  endtask

  task automatic model_reset(int k);
    m_wptr[k] = 0;
    m_acc[k]  = 1'b1;
  endtask

  // Offer one beat for exactly one cycle. Return 1 ns after the accepting edge.
  task automatic beat(int k, logic [63:0] d, logic last);
    ld_valid[k] = 1'b1;
    ld_data[k]  = d;
    ld_last[k]  = last;
    if (m_acc[k]) begin
      if (m_wptr[k] == m_full[k]) begin
        m_acc[k] = 1'b0;
      end else begin
        push(k, {32'(m_wptr[k] * 8), d});
        m_wptr[k]++;
        if (last) m_acc[k] = 1'b0;
      end
    end
    step();
    ld_valid[k] = 1'b0;
    ld_data[k]  = {$urandom, $urandom};
    ld_last[k]  = 1'($urandom_range(0, 1));
  endtask

  task automatic rst(int k);
    rstn[k] = 1'b0;
    step();
    step();
    if (k == 0) begin
      chk("sb0_empty_at_reset", 96'(sb0.size()), 96'd0);
      sb0.delete();
    end else begin
      chk("sb1_empty_at_reset", 96'(sb1.size()), 96'd0);
      sb1.delete();
    end
    model_reset(k);
    rstn[k] = 1'b1;
  endtask

  // Write monitors: every mem_we must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we[0] === 1'b1) begin
      if (sb0.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL wr0_unexpected got addr=%0h din=%0h expected=no write", mem_addr[0], mem_din[0]);
      end else begin
        chk("wr0", {mem_addr[0], mem_din[0]}, sb0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (mem_we[1] === 1'b1) begin
      if (sb1.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL wr1_unexpected got addr=%0h din=%0h expected=no write", mem_addr[1], mem_din[1]);
      end else begin
        chk("wr1", {mem_addr[1], mem_din[1]}, sb1.pop_front());
      end
    end
  end

  initial begin
    m_full[0] = 1 << 14;
    m_full[1] = 1 << 2;
    for (int k = 0; k < 2; k++) begin
      rstn[k]       = 1'b0;
      ld_valid[k]   = 1'b0;
      ld_data[k]    = '0;
      ld_last[k]    = 1'b0;
      fetch_addr[k] = '0;
      model_reset(k);
    end

    // Reset state.
    step();
    step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_word_count", wc(k), 0);
      chk("rst_ld_ready", ld_ready[k], 1);
      chk("rst_core_hold", core_hold[k], 1);
      chk("rst_mem_we", mem_we[k], 0);
      chk("rst_mem_addr", mem_addr[k], 0);
      chk("rst_mem_din", mem_din[k], 0);
      chk("rst_run_start", run_start[k], 0);
      chk("rst_load_err", load_err[k], 0);
    end
    @(posedge clk);
    #1;
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;

    // Three back-to-back beats, the last one marked final.
    beat(0, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
    beat(0, 64'hBBBB_BBBB_BBBB_BBBB, 1'b0);
    beat(0, 64'hCCCC_CCCC_CCCC_CCCC, 1'b1);
    @(negedge clk);
    chk("drain_ld_ready", ld_ready[0], 0);
    chk("drain_core_hold", core_hold[0], 1);
    chk("drain_run_start", run_start[0], 0);
    step();
    @(negedge clk);
    chk("run_core_hold", core_hold[0], 0);
    chk("run_start_pulse", run_start[0], 1);
    chk("run_word_count", wc(0), 3);
    step();
    @(negedge clk);
    chk("run_start_gone", run_start[0], 0);

    // In RUN the fetch address drives the memory address combinationally,
    // and loader beats are refused.
    #1;
    fetch_addr[0] = 32'd5;
    #1;
    chk("fetch_addr_5", mem_addr[0], 32'h28);
    fetch_addr[0] = 32'd7;
    #1;
    chk("fetch_addr_7", mem_addr[0], 32'h38);
    ld_valid[0] = 1'b1;
    ld_data[0]  = 64'hDEAD_BEEF_0000_0001;
    #1;
    chk("run_ld_ready", ld_ready[0], 0);
    step();
    @(negedge clk);
    chk("run_no_write", mem_we[0], 0);
    chk("run_word_count_held", wc(0), 3);
    #1;
    ld_valid[0]   = 1'b0;
    fetch_addr[0] = '0;

    // Valid toggling 1,0,1 with garbage data in the gaps.
    rst(0);
    beat(0, 64'h1111_0000_2222_0000, 1'b0);
    step();
    beat(0, 64'h3333_0000_4444_0000, 1'b0);
    step();
    step();
    beat(0, 64'h5555_0000_6666_0000, 1'b1);
    step();
    @(negedge clk);
    chk("gap_word_count", wc(0), 3);
    chk("gap_run_start", run_start[0], 1);

    // Small memory: four beats fill it, and a fifth beat overflows.
    rst(1);
    for (int i = 0; i < 4; i++) beat(1, 64'h0F00_0000_0000_0000 + 64'(i), 1'b0);
    beat(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    @(negedge clk);
    chk("ovf_load_err", load_err[1], 1);
    chk("ovf_core_hold", core_hold[1], 1);
    chk("ovf_ld_ready", ld_ready[1], 0);
    chk("ovf_word_count", wc(1), 4);
    chk("ovf_mem_we", mem_we[1], 0);
    beat(1, 64'h0123_4567_89AB_CDEF, 1'b1);
    @(negedge clk);
    chk("err_sticky", load_err[1], 1);
    chk("err_word_count", wc(1), 4);

    // Small memory: a final word in the last slot is legal.
    rst(1);
    for (int i = 0; i < 3; i++) beat(1, 64'h0A00_0000_0000_0000 + 64'(i), 1'b0);
    beat(1, 64'h0A00_0000_0000_00FF, 1'b1);
    @(negedge clk);
    chk("full_last_load_err", load_err[1], 0);
    step();
    @(negedge clk);
    chk("full_last_core_hold", core_hold[1], 0);
    chk("full_last_run_start", run_start[1], 1);
    chk("full_last_word_count", wc(1), 4);
    chk("full_last_load_err2", load_err[1], 0);

    // Reset applied in the cycle after the second accepted beat.
    rst(0);
    beat(0, 64'h7777_7777_0000_0001, 1'b0);
    beat(0, 64'h7777_7777_0000_0002, 1'b0);
    rstn[0] = 1'b0;
    step();
    @(negedge clk);
    chk("midrst_no_write", mem_we[0], 0);
    chk("midrst_word_count", wc(0), 0);
    chk("midrst_ld_ready", ld_ready[0], 1);
    chk("midrst_core_hold", core_hold[0], 1);
    chk("midrst_mem_addr", mem_addr[0], 0);
    #1;
    rstn[0] = 1'b1;
    chk("midrst_sb_empty", 96'(sb0.size()), 96'd0);
    sb0.delete();
    model_reset(0);
    step();
    beat(0, 64'h8888_0000_0000_0001, 1'b0);
    beat(0, 64'h8888_0000_0000_0002, 1'b1);
    step();
    @(negedge clk);
    chk("reload_word_count", wc(0), 2);

    step();
    step();
    chk("sb0_drained", 96'(sb0.size()), 96'd0);
    chk("sb1_drained", 96'(sb1.size()), 96'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 14, meaning log2 of the number of 64-bit instruction words in the instruction memory.
REQ-002 SHALL have input clk, 1 bit: clock; all state changes on its rising edge.
REQ-003 SHALL have input rstn, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have input ld_valid, 1 bit: loader offers a 64-bit instruction word.
REQ-005 SHALL have input ld_data, 64 bits: offered instruction word, two 32-bit instructions packed.
REQ-006 SHALL have input ld_last, 1 bit: qualifies ld_valid; the offered word is the final word of the program.
REQ-007 SHALL have output ld_ready, 1 bit: controller accepts the offered word this cycle.
REQ-008 SHALL have input fetch_addr, 32 bits: word index requested by the fetch stage.
REQ-009 SHALL have output mem_addr, 32 bits: byte address to the instruction memory port.
REQ-010 SHALL have output mem_din, 64 bits: write data to the instruction memory.
REQ-011 SHALL have output mem_we, 1 bit: write enable to the instruction memory.
REQ-012 SHALL have output core_hold, 1 bit: holds the fetch stage in interlock while high.
REQ-013 SHALL have output run_start, 1 bit: single-cycle pulse on entry to RUN.
REQ-014 SHALL have output load_err, 1 bit: sticky overflow error.
REQ-015 SHALL have output word_count, DEPTH_LOG2+1 bits: number of words accepted since reset.

Function
REQ-016 SHALL implement states IDLE, LOAD, DRAIN, RUN and ERROR.
REQ-017 SHALL define a beat as accepted when ld_valid and ld_ready are both 1 on a rising edge.
REQ-018 SHALL drive ld_ready=1 in IDLE and LOAD, and 0 in DRAIN, RUN and ERROR; ld_ready SHALL be a decode of state only.
REQ-019 SHALL transition IDLE->LOAD on an accepted beat with ld_last=0, and IDLE->DRAIN on an accepted beat with ld_last=1.
REQ-020 SHALL transition LOAD->DRAIN on an accepted beat with ld_last=1, otherwise remain in LOAD.
REQ-021 SHALL transition DRAIN->RUN unconditionally after exactly 1 cycle.
REQ-022 SHALL remain in RUN and in ERROR until reset.
REQ-023 SHALL keep an internal write pointer wptr, DEPTH_LOG2+1 bits, reset 0, incremented by 1 per accepted beat; word_count SHALL equal wptr.
REQ-024 SHALL, for a beat accepted at edge N, drive mem_we=1, mem_addr={wptr_old[28:0],3'b000} and mem_din=ld_data_old for the cycle after edge N, using registered values.
REQ-025 SHALL drive mem_we=0 in every cycle not covered by REQ-024.
REQ-026 SHALL, in RUN with no pending write, drive mem_addr={fetch_addr[28:0],3'b000} combinationally; in all other states mem_addr SHALL hold its last registered value.
REQ-027 SHALL drive core_hold=1 in all states except RUN, and 0 in RUN.
REQ-028 SHALL raise run_start for exactly the first cycle in RUN.
REQ-029 SHALL, on an accepted beat when wptr = 2^DEPTH_LOG2 and ld_last=0, not write, leave wptr unchanged, enter ERROR and set load_err=1.
REQ-030 SHALL treat a beat accepted at wptr = 2^DEPTH_LOG2-1 with ld_last=1 as a legal final write, with no error.
REQ-031 SHALL ignore ld_data and ld_last when ld_valid=0, and ignore ld_valid outside IDLE and LOAD.

Reset
REQ-032 SHALL, while rstn=0 at a rising edge, set state=IDLE, wptr=0, mem_we=0, mem_addr=0, mem_din=0, run_start=0 and load_err=0; core_hold=1 and ld_ready=1 follow from the IDLE decode.
REQ-033 SHALL, on reset asserted mid-LOAD or mid-RUN, abandon the operation without issuing a write in the cycle after the reset edge, and restart in IDLE.

Verification
REQ-034 Three beats 0xA..A, 0xB..B, 0xC..C(last) -> mem_we pulses with mem_addr 0x0, 0x8, 0x10 and matching mem_din; DRAIN lasts 1 cycle; run_start is a 1-cycle pulse; word_count=3; core_hold falls with RUN entry.
REQ-035 ld_valid toggled 1,0,1 between beats -> only valid cycles write; addresses stay contiguous; no write in idle gaps.
REQ-036 In RUN, fetch_addr=5 -> mem_addr=0x28 in the same cycle; ld_valid=1 -> ld_ready=0, mem_we=0.
REQ-037 DEPTH_LOG2=2: 4 beats without ld_last followed by a fifth beat -> 4 writes, then load_err=1, state ERROR, core_hold=1, word_count=4.
REQ-038 DEPTH_LOG2=2: 4th beat with ld_last=1 -> RUN, load_err=0.
REQ-039 rstn=0 in the cycle after the 2nd accepted beat -> no write in the next cycle; word_count=0; IDLE; a fresh load then starts at mem_addr 0x0.
